// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
//
// Holds ALU / branch / JAL / JALR / AUIPC micro-ops handed over by Issue until
// both source operands are known, then dispatches at most one ready entry per
// cycle to the ALU through registered outputs.
//
// Ports
//   clk_in, rst_in, rdy_in      clock, async active-high reset, global enable
//   _clear                      pipeline flush (drops every entry)
//   _rs_*                       incoming micro-op from Issue (_rs_ready = valid)
//   _rs_full                    combinational back-pressure to Issue
//   _cdb_alu_*, _cdb_lsb_*      result broadcasts used for operand wakeup
//   _alu_*                      registered dispatch to the ALU (_alu_ready
//                               is a one-cycle pulse)
// ---------------------------------------------------------------------------
module reservation_station #(
    parameter int RS_SIZE = 8,
    parameter int IDX_W   = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _rs_ready,
    input  logic [6:0]  _rs_type,
    input  logic [3:0]  _rs_op,
    input  logic [4:0]  _rs_rob_id,
    input  logic [31:0] _rs_r1,
    input  logic [31:0] _rs_r2,
    input  logic [31:0] _rs_imm,
    input  logic        _rs_has_dep1,
    input  logic [4:0]  _rs_dep1,
    input  logic        _rs_has_dep2,
    input  logic [4:0]  _rs_dep2,
    output logic        _rs_full,
    input  logic        _cdb_alu_ready,
    input  logic [4:0]  _cdb_alu_rob_id,
    input  logic [31:0] _cdb_alu_value,
    input  logic        _cdb_lsb_ready,
    input  logic [4:0]  _cdb_lsb_rob_id,
    input  logic [31:0] _cdb_lsb_value,
    output logic        _alu_ready,
    output logic [6:0]  _alu_type,
    output logic [3:0]  _alu_op,
    output logic [4:0]  _alu_rob_id,
    output logic [31:0] _alu_r1,
    output logic [31:0] _alu_r2,
    output logic [31:0] _alu_imm
);

    localparam int              SEL_W      = $clog2(RS_SIZE);
    localparam logic [IDX_W-1:0] FULL_COUNT = IDX_W'(RS_SIZE);

    // Entry storage
    logic [RS_SIZE-1:0] valid_reg;
    logic [RS_SIZE-1:0] has_dep1_reg;
    logic [RS_SIZE-1:0] has_dep2_reg;
    logic [6:0]         type_reg [RS_SIZE];
    logic [3:0]         op_reg   [RS_SIZE];
    logic [4:0]         rob_reg  [RS_SIZE];
    logic [31:0]        r1_reg   [RS_SIZE];
    logic [31:0]        r2_reg   [RS_SIZE];
    logic [31:0]        imm_reg  [RS_SIZE];
    logic [4:0]         dep1_reg [RS_SIZE];
    logic [4:0]         dep2_reg [RS_SIZE];
    logic [IDX_W-1:0]   count_reg;

    // Dispatch registers
    logic        alu_ready_reg;
    logic [6:0]  alu_type_reg;
    logic [3:0]  alu_op_reg;
    logic [4:0]  alu_rob_reg;
    logic [31:0] alu_r1_reg;
    logic [31:0] alu_r2_reg;
    logic [31:0] alu_imm_reg;

    logic full;
    assign full     = (count_reg == FULL_COUNT);
    assign _rs_full = full;

    // ------------------------------------------------------------------
    // Per-entry wakeup and readiness. The ALU bus is tested first so it
    // wins if both buses carry the same tag.
    // ------------------------------------------------------------------
    logic [RS_SIZE-1:0] ready_mask;
    logic [RS_SIZE-1:0] wake1;
    logic [RS_SIZE-1:0] wake2;
    logic [31:0]        wake1_val [RS_SIZE];
    logic [31:0]        wake2_val [RS_SIZE];

    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            logic alu_hit1, lsb_hit1, alu_hit2, lsb_hit2;
            assign alu_hit1 = _cdb_alu_ready && (_cdb_alu_rob_id == dep1_reg[gi]);
            assign lsb_hit1 = _cdb_lsb_ready && (_cdb_lsb_rob_id == dep1_reg[gi]);
            assign alu_hit2 = _cdb_alu_ready && (_cdb_alu_rob_id == dep2_reg[gi]);
            assign lsb_hit2 = _cdb_lsb_ready && (_cdb_lsb_rob_id == dep2_reg[gi]);

            assign wake1[gi]     = valid_reg[gi] && has_dep1_reg[gi] && (alu_hit1 || lsb_hit1);
            assign wake2[gi]     = valid_reg[gi] && has_dep2_reg[gi] && (alu_hit2 || lsb_hit2);
            assign wake1_val[gi] = alu_hit1 ? _cdb_alu_value : _cdb_lsb_value;
            assign wake2_val[gi] = alu_hit2 ? _cdb_alu_value : _cdb_lsb_value;

            assign ready_mask[gi] = valid_reg[gi] && !has_dep1_reg[gi] && !has_dep2_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Same-cycle bypass for the incoming micro-op
    // ------------------------------------------------------------------
    logic        in_alu_hit1, in_lsb_hit1, in_alu_hit2, in_lsb_hit2;
    logic        in_has_dep1, in_has_dep2;
    logic [31:0] in_r1, in_r2;

    assign in_alu_hit1 = _rs_has_dep1 && _cdb_alu_ready && (_cdb_alu_rob_id == _rs_dep1);
    assign in_lsb_hit1 = _rs_has_dep1 && _cdb_lsb_ready && (_cdb_lsb_rob_id == _rs_dep1);
    assign in_alu_hit2 = _rs_has_dep2 && _cdb_alu_ready && (_cdb_alu_rob_id == _rs_dep2);
    assign in_lsb_hit2 = _rs_has_dep2 && _cdb_lsb_ready && (_cdb_lsb_rob_id == _rs_dep2);

    assign in_has_dep1 = _rs_has_dep1 && !(in_alu_hit1 || in_lsb_hit1);
    assign in_has_dep2 = _rs_has_dep2 && !(in_alu_hit2 || in_lsb_hit2);
    assign in_r1 = in_alu_hit1 ? _cdb_alu_value : (in_lsb_hit1 ? _cdb_lsb_value : _rs_r1);
    assign in_r2 = in_alu_hit2 ? _cdb_alu_value : (in_lsb_hit2 ? _cdb_lsb_value : _rs_r2);

    // ------------------------------------------------------------------
    // Lowest-index free slot and lowest-index ready slot (pre-edge state)
    // ------------------------------------------------------------------
    logic             alloc_found;
    logic [SEL_W-1:0] alloc_idx;
    logic             sel_found;
    logic [SEL_W-1:0] sel_idx;
    logic             alloc_en;

    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        sel_found   = 1'b0;
        sel_idx     = '0;
        // Scan downward so the last hit written is the lowest index.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = SEL_W'(i);
            end
            if (ready_mask[i]) begin
                sel_found = 1'b1;
                sel_idx   = SEL_W'(i);
            end
        end
    end

    assign alloc_en = _rs_ready && !full && alloc_found;

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_reg     <= '0;
            has_dep1_reg  <= '0;
            has_dep2_reg  <= '0;
            count_reg     <= '0;
            alu_ready_reg <= 1'b0;
            alu_type_reg  <= '0;
            alu_op_reg    <= '0;
            alu_rob_reg   <= '0;
            alu_r1_reg    <= '0;
            alu_r2_reg    <= '0;
            alu_imm_reg   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                type_reg[i] <= '0;
                op_reg[i]   <= '0;
                rob_reg[i]  <= '0;
                r1_reg[i]   <= '0;
                r2_reg[i]   <= '0;
                imm_reg[i]  <= '0;
                dep1_reg[i] <= '0;
                dep2_reg[i] <= '0;
            end
        end else if (rdy_in) begin
            if (_clear) begin
                valid_reg     <= '0;
                count_reg     <= '0;
                alu_ready_reg <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (alloc_en && (alloc_idx == SEL_W'(i))) begin
                        valid_reg[i]    <= 1'b1;
                        type_reg[i]     <= _rs_type;
                        op_reg[i]       <= _rs_op;
                        rob_reg[i]      <= _rs_rob_id;
                        r1_reg[i]       <= in_r1;
                        r2_reg[i]       <= in_r2;
                        imm_reg[i]      <= _rs_imm;
                        has_dep1_reg[i] <= in_has_dep1;
                        dep1_reg[i]     <= _rs_dep1;
                        has_dep2_reg[i] <= in_has_dep2;
                        dep2_reg[i]     <= _rs_dep2;
                    end else begin
                        if (wake1[i]) begin
                            r1_reg[i]       <= wake1_val[i];
                            has_dep1_reg[i] <= 1'b0;
                        end
                        if (wake2[i]) begin
                            r2_reg[i]       <= wake2_val[i];
                            has_dep2_reg[i] <= 1'b0;
                        end
                    end
                end

                // The selected slot is valid, the allocated one is not, so
                // the two writes to valid_reg never target the same bit.
                if (sel_found) begin
                    valid_reg[sel_idx] <= 1'b0;
                    alu_ready_reg      <= 1'b1;
                    alu_type_reg       <= type_reg[sel_idx];
                    alu_op_reg         <= op_reg[sel_idx];
                    alu_rob_reg        <= rob_reg[sel_idx];
                    alu_r1_reg         <= r1_reg[sel_idx];
                    alu_r2_reg         <= r2_reg[sel_idx];
                    alu_imm_reg        <= imm_reg[sel_idx];
                end else begin
                    alu_ready_reg <= 1'b0;
                end

                case ({alloc_en, sel_found})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    assign _alu_ready  = alu_ready_reg;
    assign _alu_type   = alu_type_reg;
    assign _alu_op     = alu_op_reg;
    assign _alu_rob_id = alu_rob_reg;
    assign _alu_r1     = alu_r1_reg;
    assign _alu_r2     = alu_r2_reg;
    assign _alu_imm    = alu_imm_reg;

endmodule

// File: tb/tb_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_reservation_station
//
// Directed vector table for the scenario walk-throughs, a few hand-written
// sequences (asynchronous reset), then randomized traffic compared against a
// behavioural model of the station.
// ---------------------------------------------------------------------------
module tb_reservation_station;

    localparam int RS = 8;

    typedef struct packed {
        logic        rdy;
        logic        clr;
        logic        iss;
        logic [6:0]  typ;
        logic [3:0]  op;
        logic [4:0]  rob;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic        h1;
        logic [4:0]  d1;
        logic        h2;
        logic [4:0]  d2;
        logic        ca;
        logic [4:0]  cat;
        logic [31:0] cav;
        logic        cl;
        logic [4:0]  clt;
        logic [31:0] clv;
    } in_t;

    typedef struct {
        in_t         i;
        logic        e_full;
        logic        e_rdy;
        logic [4:0]  e_rob;
        logic [31:0] e_r1;
        logic [31:0] e_r2;
        logic [31:0] e_imm;
    } vec_t;

    typedef struct packed {
        logic        v;
        logic [6:0]  typ;
        logic [3:0]  op;
        logic [4:0]  rob;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic        h1;
        logic [4:0]  d1;
        logic        h2;
        logic [4:0]  d2;
    } ent_t;

    typedef struct packed {
        logic        ardy;
        logic [6:0]  typ;
        logic [3:0]  op;
        logic [4:0]  rob;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
    } out_t;

    // DUT signals
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        rs_ready;
    logic [6:0]  rs_type;
    logic [3:0]  rs_op;
    logic [4:0]  rs_rob_id;
    logic [31:0] rs_r1, rs_r2, rs_imm;
    logic        rs_has_dep1, rs_has_dep2;
    logic [4:0]  rs_dep1, rs_dep2;
    logic        rs_full;
    logic        cdb_alu_ready, cdb_lsb_ready;
    logic [4:0]  cdb_alu_rob_id, cdb_lsb_rob_id;
    logic [31:0] cdb_alu_value, cdb_lsb_value;
    logic        alu_ready;
    logic [6:0]  alu_type;
    logic [3:0]  alu_op;
    logic [4:0]  alu_rob_id;
    logic [31:0] alu_r1, alu_r2, alu_imm;

    reservation_station #(.RS_SIZE(RS), .IDX_W(4)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        ._clear          (clear),
        ._rs_ready       (rs_ready),
        ._rs_type        (rs_type),
        ._rs_op          (rs_op),
        ._rs_rob_id      (rs_rob_id),
        ._rs_r1          (rs_r1),
        ._rs_r2          (rs_r2),
        ._rs_imm         (rs_imm),
        ._rs_has_dep1    (rs_has_dep1),
        ._rs_dep1        (rs_dep1),
        ._rs_has_dep2    (rs_has_dep2),
        ._rs_dep2        (rs_dep2),
        ._rs_full        (rs_full),
        ._cdb_alu_ready  (cdb_alu_ready),
        ._cdb_alu_rob_id (cdb_alu_rob_id),
        ._cdb_alu_value  (cdb_alu_value),
        ._cdb_lsb_ready  (cdb_lsb_ready),
        ._cdb_lsb_rob_id (cdb_lsb_rob_id),
        ._cdb_lsb_value  (cdb_lsb_value),
        ._alu_ready      (alu_ready),
        ._alu_type       (alu_type),
        ._alu_op         (alu_op),
        ._alu_rob_id     (alu_rob_id),
        ._alu_r1         (alu_r1),
        ._alu_r2         (alu_r2),
        ._alu_imm        (alu_imm)
    );

    always #5 clk_in = ~clk_in;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    ent_t m [RS];
    out_t mo;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t x);
        rdy_in         = x.rdy;
        clear          = x.clr;
        rs_ready       = x.iss;
        rs_type        = x.typ;
        rs_op          = x.op;
        rs_rob_id      = x.rob;
        rs_r1          = x.r1;
        rs_r2          = x.r2;
        rs_imm         = x.imm;
        rs_has_dep1    = x.h1;
        rs_dep1        = x.d1;
        rs_has_dep2    = x.h2;
        rs_dep2        = x.d2;
        cdb_alu_ready  = x.ca;
        cdb_alu_rob_id = x.cat;
        cdb_alu_value  = x.cav;
        cdb_lsb_ready  = x.cl;
        cdb_lsb_rob_id = x.clt;
        cdb_lsb_value  = x.clv;
    endtask

    function automatic in_t idle();
        in_t x;
        x     = '0;
        x.rdy = 1'b1;
        return x;
    endfunction

    function automatic in_t iss(input logic [4:0] rob, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] imm,
                                input logic h1, input logic [4:0] d1,
                                input logic h2, input logic [4:0] d2);
        in_t x;
        x     = idle();
        x.iss = 1'b1;
        x.typ = 7'b0010011;
        x.op  = rob[3:0];
        x.rob = rob;
        x.r1  = r1;
        x.r2  = r2;
        x.imm = imm;
        x.h1  = h1;
        x.d1  = d1;
        x.h2  = h2;
        x.d2  = d2;
        return x;
    endfunction

    task automatic add(input in_t x, input logic ef, input logic er, input logic [4:0] rob,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm);
        vec_t v;
        v.i = x; v.e_full = ef; v.e_rdy = er; v.e_rob = rob;
        v.e_r1 = r1; v.e_r2 = r2; v.e_imm = imm;
        tbl.push_back(v);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic int nvalid();
        int c = 0;
        for (int i = 0; i < RS; i++) if (m[i].v) c++;
        return c;
    endfunction

    // {still pending, operand value} after looking at this cycle's buses
    function automatic logic [32:0] resolve(input logic h, input logic [4:0] tag,
                                            input logic [31:0] val, input in_t x);
        if (!h) return {1'b0, val};
        if (x.ca && x.cat == tag) return {1'b0, x.cav};
        if (x.cl && x.clt == tag) return {1'b0, x.clv};
        return {1'b1, val};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS; i++) m[i] = '0;
        mo = '0;
    endtask

    task automatic model_step(input in_t x);
        ent_t        nx [RS];
        int          sel, al;
        logic [32:0] rv;
        if (!x.rdy) return;
        if (x.clr) begin
            for (int i = 0; i < RS; i++) m[i].v = 1'b0;
            mo.ardy = 1'b0;
            return;
        end
        sel = -1;
        for (int i = 0; i < RS; i++)
            if (sel < 0 && m[i].v && !m[i].h1 && !m[i].h2) sel = i;
        al = -1;
        if (x.iss && nvalid() < RS)
            for (int i = 0; i < RS; i++)
                if (al < 0 && !m[i].v) al = i;
        nx = m;
        for (int i = 0; i < RS; i++) begin
            if (m[i].v) begin
                rv = resolve(m[i].h1, m[i].d1, m[i].r1, x);
                nx[i].h1 = rv[32]; nx[i].r1 = rv[31:0];
                rv = resolve(m[i].h2, m[i].d2, m[i].r2, x);
                nx[i].h2 = rv[32]; nx[i].r2 = rv[31:0];
            end
        end
        if (sel >= 0) begin
            mo.ardy = 1'b1;
            mo.typ  = m[sel].typ;
            mo.op   = m[sel].op;
            mo.rob  = m[sel].rob;
            mo.r1   = m[sel].r1;
            mo.r2   = m[sel].r2;
            mo.imm  = m[sel].imm;
            nx[sel].v = 1'b0;
        end else begin
            mo.ardy = 1'b0;
        end
        if (al >= 0) begin
            nx[al].v   = 1'b1;
            nx[al].typ = x.typ;
            nx[al].op  = x.op;
            nx[al].rob = x.rob;
            nx[al].imm = x.imm;
            nx[al].d1  = x.d1;
            nx[al].d2  = x.d2;
            rv = resolve(x.h1, x.d1, x.r1, x);
            nx[al].h1 = rv[32]; nx[al].r1 = rv[31:0];
            rv = resolve(x.h2, x.d2, x.r2, x);
            nx[al].h2 = rv[32]; nx[al].r2 = rv[31:0];
        end
        m = nx;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        drive(idle());
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Test
    // ------------------------------------------------------------------
    initial begin
        in_t x;

        // ---- directed vector table ----
        // ADDI with no dependencies
        add(iss(5'd3, 32'd5, 32'd0, 32'd7, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
        add(idle(), 0, 1, 5'd3, 32'd5, 32'd0, 32'd7);
        add(idle(), 0, 0, 0, 0, 0, 0);
        // operand 1 woken by the LSB bus two cycles later
        add(iss(5'd5, 32'hDEAD, 32'd2, 32'd0, 1, 5'd4, 0, 0), 0, 0, 0, 0, 0, 0);
        add(idle(), 0, 0, 0, 0, 0, 0);
        add(idle(), 0, 0, 0, 0, 0, 0);
        x = idle(); x.cl = 1; x.clt = 5'd4; x.clv = 32'h1234;
        add(x, 0, 0, 0, 0, 0, 0);
        add(idle(), 0, 1, 5'd5, 32'h1234, 32'd2, 32'd0);
        add(idle(), 0, 0, 0, 0, 0, 0);
        // operand 2 captured by same-cycle bypass from the ALU bus
        x = iss(5'd7, 32'd1, 32'd0, 32'd0, 0, 0, 1, 5'd6);
        x.ca = 1; x.cat = 5'd6; x.cav = 32'd99;
        add(x, 0, 0, 0, 0, 0, 0);
        add(idle(), 0, 1, 5'd7, 32'd1, 32'd99, 32'd0);
        add(idle(), 0, 0, 0, 0, 0, 0);
        // allocate and select in the same cycle
        add(iss(5'd8, 32'd10, 32'd0, 32'd0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
        add(iss(5'd9, 32'd11, 32'd0, 32'd0, 0, 0, 0, 0), 0, 1, 5'd8, 32'd10, 32'd0, 32'd0);
        add(idle(), 0, 1, 5'd9, 32'd11, 32'd0, 32'd0);
        add(idle(), 0, 0, 0, 0, 0, 0);
        // fill all entries behind tag 9, then release them
        for (int k = 0; k < RS; k++)
            add(iss(5'(10 + k), 32'd0, 32'(k), 32'(100 + k), 1, 5'd9, 0, 0), 0, 0, 0, 0, 0, 0);
        add(idle(), 1, 0, 0, 0, 0, 0);
        x = iss(5'd31, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0);     // dropped: station full
        x.ca = 1; x.cat = 5'd9; x.cav = 32'h99;
        add(x, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < RS; k++)
            add(idle(), (k == 0), 1, 5'(10 + k), 32'h99, 32'(k), 32'(100 + k));
        add(idle(), 0, 0, 0, 0, 0, 0);
        // flush beats a simultaneous issue and wakeup
        for (int k = 1; k <= 3; k++)
            add(iss(5'(k), 32'd0, 32'd0, 32'd0, 1, 5'd20, 0, 0), 0, 0, 0, 0, 0, 0);
        x = iss(5'd4, 32'd4, 32'd0, 32'd0, 0, 0, 0, 0);
        x.clr = 1; x.ca = 1; x.cat = 5'd20; x.cav = 32'd1;
        add(x, 0, 0, 0, 0, 0, 0);
        add(idle(), 0, 0, 0, 0, 0, 0);
        add(idle(), 0, 0, 0, 0, 0, 0);
        // rdy_in low freezes everything, including the dispatch outputs
        add(iss(5'd14, 32'd0, 32'd0, 32'd0, 1, 5'd21, 0, 0), 0, 0, 0, 0, 0, 0);
        add(iss(5'd12, 32'd3, 32'd0, 32'd0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
        add(idle(), 0, 1, 5'd12, 32'd3, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            x = iss(5'd13, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0);
            x.rdy = 0; x.ca = 1; x.cat = 5'd21; x.cav = 32'h55;
            add(x, 0, 1, 5'd12, 32'd3, 32'd0, 32'd0);
        end
        add(idle(), 0, 0, 0, 0, 0, 0);
        add(idle(), 0, 0, 0, 0, 0, 0);
        x = idle(); x.cl = 1; x.clt = 5'd21; x.clv = 32'h66;
        add(x, 0, 0, 0, 0, 0, 0);
        add(idle(), 0, 1, 5'd14, 32'h66, 32'd0, 32'd0);
        add(idle(), 0, 0, 0, 0, 0, 0);

        // ---- reset state ----
        rst_in = 1'b1;
        drive(idle());
        #12;
        chk("reset alu_ready", 32'(alu_ready), 0);
        chk("reset alu_rob_id", 32'(alu_rob_id), 0);
        chk("reset alu_r1", alu_r1, 0);
        chk("reset alu_imm", alu_imm, 0);
        chk("reset rs_full", 32'(rs_full), 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // ---- apply table ----
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk_in);
            drive(tbl[k].i);
            #1;
            chk($sformatf("vec%0d rs_full", k), 32'(rs_full), 32'(tbl[k].e_full));
            @(posedge clk_in);
            #1;
            chk($sformatf("vec%0d alu_ready", k), 32'(alu_ready), 32'(tbl[k].e_rdy));
            if (tbl[k].e_rdy) begin
                chk($sformatf("vec%0d alu_rob_id", k), 32'(alu_rob_id), 32'(tbl[k].e_rob));
                chk($sformatf("vec%0d alu_r1", k), alu_r1, tbl[k].e_r1);
                chk($sformatf("vec%0d alu_r2", k), alu_r2, tbl[k].e_r2);
                chk($sformatf("vec%0d alu_imm", k), alu_imm, tbl[k].e_imm);
            end
            $display("vec %0d: full=%0d ready=%0d rob=%0d r1=%0h", k, rs_full, alu_ready, alu_rob_id, alu_r1);
        end

        // ---- asynchronous reset while a dispatch is showing ----
        @(negedge clk_in);
        drive(iss(5'd22, 32'hABCD, 32'd1, 32'd2, 0, 0, 0, 0));
        @(negedge clk_in);
        drive(idle());
        @(posedge clk_in);
        #1;
        chk("pre-reset alu_ready", 32'(alu_ready), 1);
        chk("pre-reset alu_rob_id", 32'(alu_rob_id), 22);
        #2;
        rst_in = 1'b1;
        #1;
        chk("async reset alu_ready", 32'(alu_ready), 0);
        chk("async reset alu_rob_id", 32'(alu_rob_id), 0);
        chk("async reset alu_r1", alu_r1, 0);
        chk("async reset alu_r2", alu_r2, 0);
        $display("async reset: ready=%0d rob=%0d r1=%0h", alu_ready, alu_rob_id, alu_r1);
        @(negedge clk_in);
        rst_in = 1'b0;

        // ---- randomized traffic against the model ----
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            x     = '0;
            x.rdy = ($urandom_range(9) != 0);
            x.clr = ($urandom_range(63) == 0);
            x.iss = ($urandom_range(99) < 60);
            x.typ = 7'($urandom);
            x.op  = 4'($urandom);
            x.rob = 5'($urandom);
            x.r1  = $urandom;
            x.r2  = $urandom;
            x.imm = $urandom;
            x.h1  = ($urandom_range(1) == 1);
            x.d1  = 5'($urandom_range(7));
            x.h2  = ($urandom_range(2) == 0);
            x.d2  = 5'($urandom_range(7));
            x.ca  = ($urandom_range(9) < 3);
            x.cat = 5'($urandom_range(7));
            x.cav = $urandom;
            x.cl  = ($urandom_range(9) < 3);
            x.clt = 5'($urandom_range(7));
            x.clv = $urandom;

            @(negedge clk_in);
            drive(x);
            #1;
            chk($sformatf("rnd%0d rs_full", n), 32'(rs_full), 32'(nvalid() == RS));
            model_step(x);
            @(posedge clk_in);
            #1;
            chk($sformatf("rnd%0d alu_ready", n), 32'(alu_ready), 32'(mo.ardy));
            if (mo.ardy) begin
                chk($sformatf("rnd%0d alu_type", n), 32'(alu_type), 32'(mo.typ));
                chk($sformatf("rnd%0d alu_op", n), 32'(alu_op), 32'(mo.op));
                chk($sformatf("rnd%0d alu_rob_id", n), 32'(alu_rob_id), 32'(mo.rob));
                chk($sformatf("rnd%0d alu_r1", n), alu_r1, mo.r1);
                chk($sformatf("rnd%0d alu_r2", n), alu_r2, mo.r2);
                chk($sformatf("rnd%0d alu_imm", n), alu_imm, mo.imm);
            end
            $display("rnd %0d: rdy=%0d clr=%0d iss=%0d full=%0d ready=%0d rob=%0d",
                     n, x.rdy, x.clr, x.iss, rs_full, alu_ready, alu_rob_id);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the Issue→ReservationStation dispatch interface.
- Buffers ALU, branch, JAL, JALR and AUIPC micro-ops until both operands are available.
- Snoops two common data buses (ALU and load/store) for operand wakeup.
- Dispatches one ready entry per cycle to the ALU through registered outputs; drives the `_rs_full` back-pressure that Issue uses to gate its pop.

Parameters:
RS_SIZE, 8, number of entries; legal range 2..16.
IDX_W, 4, width of the internal occupancy counter; must satisfy 2^IDX_W > RS_SIZE.

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-high
rdy_in  input  1  global ready; state frozen when low
_clear  input  1  pipeline flush (misprediction)
_rs_ready  input  1  issue valid
_rs_type  input  7  opcode
_rs_op  input  4  ALU/branch sub-op
_rs_rob_id  input  5  destination ROB tag
_rs_r1  input  32  operand 1 value (valid when no dep1)
_rs_r2  input  32  operand 2 value
_rs_imm  input  32  immediate
_rs_has_dep1  input  1  operand 1 pending
_rs_dep1  input  5  operand 1 producer tag
_rs_has_dep2  input  1  operand 2 pending
_rs_dep2  input  5  operand 2 producer tag
_rs_full  output  1  no free entry
_cdb_alu_ready  input  1  ALU result broadcast valid
_cdb_alu_rob_id  input  5  ALU result tag
_cdb_alu_value  input  32  ALU result
_cdb_lsb_ready  input  1  LSB result broadcast valid
_cdb_lsb_rob_id  input  5  LSB result tag
_cdb_lsb_value  input  32  LSB result
_alu_ready  output  1  dispatch valid, one-cycle pulse
_alu_type  output  7  opcode
_alu_op  output  4  sub-op
_alu_rob_id  output  5  ROB tag
_alu_r1  output  32  operand 1
_alu_r2  output  32  operand 2
_alu_imm  output  32  immediate

Behaviour:
Reset:
- All entries invalid.
- `_alu_ready` = 0; all `_alu_*` data outputs = 0.
- `_rs_full` = 0.

rdy_in low:
- No state change; issue input ignored.
- Registered outputs hold their values.

Per entry state: valid, type, op, rob_id, r1, r2, imm, has_dep1, dep1, has_dep2, dep2.

`_rs_full`:
- Combinational: 1 when count == RS_SIZE.
- Based on current registered state only; an entry freed this cycle does not lower full until the next cycle.
- Issue never asserts `_rs_ready` while full. If it does, the input is dropped.

Allocate (on the clock edge when `_rs_ready` is high and the block is not full):
- Write to the lowest-index invalid entry.
- Same-cycle bypass: if `_rs_has_dep1` is high and a CDB in this cycle carries tag == `_rs_dep1`, store that CDB value into r1 and clear has_dep1. Same rule for operand 2.
- The has_dep flags are authoritative; tag 0 carries no special meaning inside this block.

Wakeup (every edge):
- For each valid entry with has_depK set and a matching CDB tag: rK <= CDB value; has_depK <= 0.
- Both CDBs are checked. ALU CDB has priority when both match (this cannot occur legally).

Select (every edge):
- Candidate: lowest-index entry with valid set and both has_dep flags clear, evaluated on pre-edge state.
- If a candidate exists: copy its fields to the `_alu_*` registers, set `_alu_ready` = 1, clear the entry's valid bit.
- Otherwise `_alu_ready` = 0.
- An entry allocated or woken at edge N is eligible no earlier than edge N+1. Minimum issue-to-`_alu_ready` latency is therefore 1 cycle after the allocating edge.

Count:
- +1 on allocate, −1 on select, unchanged when both happen in the same cycle.
- Allocate and select may target different entries in the same cycle. The freed entry is not reused until the next cycle.

`_clear` (synchronous, with rdy_in high):
- All entries invalid, count = 0, `_alu_ready` = 0.
- Overrides allocate, wakeup and select in that cycle.

Reset mid-operation: asynchronous return to the reset state on any cycle.

Test Plan:
1. Issue ADDI (type 0010011, op 0, rob 3, r1=5, imm=7, no deps) at edge N → `_alu_ready`=1 after edge N+1 with rob_id 3, r1 5, imm 7; low the following cycle.
2. Issue op with has_dep1=1, dep1=4; two cycles later `_cdb_lsb_ready`=1, tag 4, value 0x1234 → dispatch one cycle after the broadcast with r1=0x1234.
3. Issue with dep2=6 in the same cycle that `_cdb_alu` broadcasts tag 6, value 99 → entry captures 99 via bypass; dispatch one cycle later with r2=99.
4. Fill 8 entries that all depend on tag 9 → `_rs_full`=1 with no dispatch. Broadcast tag 9 → entries 0..7 dispatch in index order, one per cycle; `_rs_full` drops after the first select edge.
5. Three pending entries plus `_clear`, with a simultaneous issue and a CDB hit → next cycle count 0, `_rs_full`=0, no `_alu_ready` afterwards.
6. Hold rdy_in low for 3 cycles while `_rs_ready` and a CDB are asserted → no allocation, no wakeup, outputs unchanged. Assert rst_in mid-stream → all outputs 0 immediately, without waiting for a clock edge.
